// File: rtl/ntt_pkg.sv
// Shared constants and types for the 128-point NTT stage sequencing logic.
package ntt_pkg;

  localparam int unsigned N_POINTS   = 128;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned STAGE_W    = 3;
  localparam int unsigned NUM_STAGES = 4;
  localparam int unsigned GROUPS     = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Index set handed to the address generator for one butterfly group.
  typedef struct packed {
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] k;
    logic [IDX_W-1:0] j;
  } idx_set_t;

endpackage

// File: rtl/ntt_index_map.sv
// Maps (stage p, group counter) to the i/k/j indices of the 4-bank address generator.
module ntt_index_map
  import ntt_pkg::*;
(
  input  logic [STAGE_W-1:0] i_p,
  input  logic [IDX_W-1:0]   i_cnt,
  output idx_set_t           o_idx_c
);

  // Stage 3 walks groups directly; lower stages split cnt into outer k / inner j.
  always_comb begin
    o_idx_c = '0;
    case (i_p)
      3'd3: o_idx_c.i = i_cnt;
      3'd2: begin
        o_idx_c.k = IDX_W'(i_cnt[4]);
        o_idx_c.j = IDX_W'(i_cnt[3:0]);
      end
      3'd1: begin
        o_idx_c.k = IDX_W'(i_cnt[4:2]);
        o_idx_c.j = IDX_W'(i_cnt[1:0]);
      end
      3'd0: o_idx_c.k = i_cnt;
      default: o_idx_c = '0;
    endcase
  end

endmodule

// File: rtl/ntt_stage_scheduler.sv
// Sequences all NTT stages, one butterfly group per accepted cycle, with a
// write-back drain gap between stages.
module ntt_stage_scheduler
  import ntt_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               bf_ready,
  output logic               bf_valid,
  output logic [STAGE_W-1:0] p,
  output logic [IDX_W-1:0]   i,
  output logic [IDX_W-1:0]   k,
  output logic [IDX_W-1:0]   j,
  output logic               stage_last,
  output logic               busy,
  output logic               done
);

  // A zero drain still costs one DRAIN cycle, so the load value saturates at 0.
  localparam int unsigned DRAIN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int unsigned DRAIN_W    = (DRAIN_LOAD > 0) ? $clog2(DRAIN_LOAD + 1) : 1;
  localparam logic [IDX_W-1:0]   CNT_LAST = IDX_W'(GROUPS - 1);
  localparam logic [STAGE_W-1:0] P_FIRST  = STAGE_W'(NUM_STAGES - 1);

  state_t               r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_cnt, w_cnt_nxt;
  logic [DRAIN_W-1:0]   r_dcnt, w_dcnt_nxt;
  logic [STAGE_W-1:0]   r_p, w_p_nxt;
  logic                 r_bf_valid, r_stage_last, r_busy, r_done;
  logic [IDX_W-1:0]     r_i, r_k, r_j;
  idx_set_t             w_idx;
  logic                 w_accept;

  assign w_accept = (r_state == ST_ISSUE) && r_bf_valid && bf_ready;

  // Next-state, group counter, drain counter and stage selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dcnt_nxt  = r_dcnt;
    w_p_nxt     = r_p;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_ISSUE;
          w_cnt_nxt   = '0;
          w_p_nxt     = P_FIRST;
        end
      end
      ST_ISSUE: begin
        if (w_accept) begin
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_DRAIN;
            w_cnt_nxt   = '0;
            w_dcnt_nxt  = DRAIN_W'(DRAIN_LOAD);
          end else begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (r_dcnt == '0) begin
          if (r_p != '0) begin
            w_p_nxt     = r_p - STAGE_W'(1);
            w_state_nxt = ST_ISSUE;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_dcnt_nxt = r_dcnt - DRAIN_W'(1);
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Indices are derived from the next stage/counter so they register alongside them.
  ntt_index_map u_index_map (
    .i_p     (w_p_nxt),
    .i_cnt   (w_cnt_nxt),
    .o_idx_c (w_idx)
  );

  // State register with counters and stage number.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dcnt  <= '0;
      r_p     <= P_FIRST;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dcnt  <= w_dcnt_nxt;
      r_p     <= w_p_nxt;
    end
  end

  // Registered handshake, status and index outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bf_valid   <= 1'b0;
      r_stage_last <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_i          <= '0;
      r_k          <= '0;
      r_j          <= '0;
    end else begin
      r_bf_valid   <= (w_state_nxt == ST_ISSUE);
      r_stage_last <= (w_state_nxt == ST_ISSUE) && (w_cnt_nxt == CNT_LAST);
      r_busy       <= (w_state_nxt == ST_ISSUE) || (w_state_nxt == ST_DRAIN);
      r_done       <= (w_state_nxt == ST_DONE);
      r_i          <= w_idx.i;
      r_k          <= w_idx.k;
      r_j          <= w_idx.j;
    end
  end

  assign bf_valid   = r_bf_valid;
  assign p          = r_p;
  assign i          = r_i;
  assign k          = r_k;
  assign j          = r_j;
  assign stage_last = r_stage_last;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Bench for ntt_stage_scheduler: transaction-level model plus directed scenarios.
module tb_ntt_stage_scheduler;

  localparam int GRP    = 32;
  localparam int DEFF_A = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, bf_ready;
  logic       a_bf_valid, a_stage_last, a_busy, a_done;
  logic [2:0] a_p;
  logic [4:0] a_i, a_k, a_j;
  logic       z_bf_valid, z_stage_last, z_busy, z_done;
  logic [2:0] z_p;
  logic [4:0] z_i, z_k, z_j;

  ntt_stage_scheduler #(.DRAIN_CYCLES(6)) dut (
    .clk(clk), .rst(rst), .start(start), .bf_ready(bf_ready),
    .bf_valid(a_bf_valid), .p(a_p), .i(a_i), .k(a_k), .j(a_j),
    .stage_last(a_stage_last), .busy(a_busy), .done(a_done)
  );

  ntt_stage_scheduler #(.DRAIN_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bf_ready(bf_ready),
    .bf_valid(z_bf_valid), .p(z_p), .i(z_i), .k(z_k), .j(z_j),
    .stage_last(z_stage_last), .busy(z_busy), .done(z_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Expected issue for stage s, group c: {p, i, k, j, stage_last}.
  function automatic logic [18:0] exp_entry(input int s, input int c);
    int ii, kk, jj;
    ii = 0; kk = 0; jj = 0;
    case (s)
      3: ii = c;
      2: begin kk = c / 16; jj = c % 16; end
      1: begin kk = c / 4;  jj = c % 4;  end
      default: kk = c;
    endcase
    return {3'(s), 5'(ii), 5'(kk), 5'(jj), (c == GRP - 1)};
  endfunction

  // Model state: phase 0 idle, 1 issuing, 2 drain gap, 3 done cycle.
  logic [18:0] exp_q[$];
  logic [18:0] acc_log[128];
  int ph = 0, g = 0, m_start_cyc = 0, m_len = 0, m_acc = 0, m_dones = 0;

  always @(negedge clk) begin
    logic [18:0] got, e;
    if (!rst) begin
      ph = 0;
      exp_q.delete();
      check("reset_outputs", {a_bf_valid, a_busy, a_done, a_stage_last, a_p}, {4'b0, 3'd3});
    end else begin
      case (ph)
        0: begin
          check("idle_ctl", {a_bf_valid, a_busy, a_done}, 3'b000);
          if (start) begin
            ph = 1;
            m_start_cyc = cyc;
            m_acc = 0;
            exp_q.delete();
            for (int s = 3; s >= 0; s--)
              for (int c = 0; c < GRP; c++) exp_q.push_back(exp_entry(s, c));
          end
        end
        1: begin
          check("issue_ctl", {a_bf_valid, a_busy, a_done}, 3'b110);
          got = {a_p, a_i, a_k, a_j, a_stage_last};
          e = (exp_q.size() > 0) ? exp_q[0] : '1;
          check("issue_idx", got, e);
          if (bf_ready) begin
            if (m_acc < 128) acc_log[m_acc] = got;
            m_acc++;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (e[0]) begin ph = 2; g = DEFF_A; end
          end
        end
        2: begin
          check("drain_ctl", {a_bf_valid, a_busy, a_done}, 3'b010);
          g--;
          if (g == 0) ph = (exp_q.size() == 0) ? 3 : 1;
        end
        default: begin
          check("done_ctl", {a_bf_valid, a_busy, a_done}, 3'b001);
          check("done_accepts", m_acc, 128);
          m_len = cyc - m_start_cyc + 1;
          m_dones++;
          ph = 0;
        end
      endcase
    end
  end

  // Zero-drain instance: gap lengths between stages and start->done length.
  bit z_en = 1'b0;
  int z_gap = 0, z_gap_n = 0, z_gap_bad = 0, z_len = 0, t_start = 0;

  always @(negedge clk) begin
    if (z_en && rst) begin
      if (z_busy && !z_bf_valid) z_gap++;
      else if ((z_bf_valid || z_done) && z_gap != 0) begin
        z_gap_n++;
        if (z_gap != 1) z_gap_bad++;
        z_gap = 0;
      end
      if (z_done) z_len = cyc - t_start + 1;
    end
  end

  task automatic run_xfer(input bit rnd, input bit extra_starts);
    int d0;
    bit seen;
    d0 = m_dones;
    seen = 1'b0;
    start = 1'b1;
    bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      start = 1'b0;
      if (extra_starts && (n == 40 || n == 75)) start = 1'b1;
      if (extra_starts && a_done) start = 1'b1;
      bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_dones > d0) begin seen = 1'b1; break; end
    end
    start = 1'b0;
    check("xfer_done_seen", seen, 1'b1);
  endtask

  task automatic check_cover(input int s);
    logic [127:0] m;
    logic [18:0] en;
    int base, idx;
    m = '0;
    for (int n = 0; n < 128; n++) begin
      en = acc_log[n];
      if (int'(en[18:16]) == s) begin
        base = int'(en[10:6]) * (1 << (2 * (s + 1))) + int'(en[5:1]);
        for (int mm = 0; mm < 4; mm++) begin
          idx = base + mm * (1 << (2 * s));
          if (idx < 128) m[idx] = 1'b1;
        end
      end
    end
    check($sformatf("cover_p%0d", s), m, {128{1'b1}});
  endtask

  initial begin
    logic [127:0] a0, a0_exp;
    logic [18:0]  en;
    int d, budget_ok;
    rst = 1'b0; start = 1'b0; bf_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;

    // Full transform, ready stuck high, both drain builds side by side.
    z_en = 1'b1;
    t_start = cyc;
    run_xfer(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 z_en = 1'b0;
    check("len_drain6", m_len, 154);
    check("len_drain0", z_len, 134);
    check("gaps_drain0", z_gap_n, 4);
    check("gap_not_one", z_gap_bad, 0);

    // Hand-computed points of the issue sequence.
    check("log_p3_first", acc_log[0],   {3'd3, 5'd0,  5'd0,  5'd0,  1'b0});
    check("log_p3_last",  acc_log[31],  {3'd3, 5'd31, 5'd0,  5'd0,  1'b1});
    check("log_p2_first", acc_log[32],  {3'd2, 5'd0,  5'd0,  5'd0,  1'b0});
    check("log_p2_k1",    acc_log[48],  {3'd2, 5'd0,  5'd1,  5'd0,  1'b0});
    check("log_p2_last",  acc_log[63],  {3'd2, 5'd0,  5'd1,  5'd15, 1'b1});
    check("log_p1_c5",    acc_log[69],  {3'd1, 5'd0,  5'd1,  5'd1,  1'b0});
    check("log_p0_last",  acc_log[127], {3'd0, 5'd0,  5'd31, 5'd0,  1'b1});

    // p=2 base addresses and per-stage point coverage.
    a0 = '0;
    for (int n = 0; n < 128; n++) begin
      en = acc_log[n];
      if (en[18:16] == 3'd2) a0[int'(en[10:6]) * 64 + int'(en[5:1])] = 1'b1;
    end
    a0_exp = {48'h0, 16'hFFFF, 48'h0, 16'hFFFF};
    check("p2_addr0_set", a0, a0_exp);
    for (int s = 0; s < 3; s++) check_cover(s);

    // Random backpressure.
    repeat (3) @(posedge clk);
    #2 run_xfer(1'b1, 1'b0);

    // Start pulses while busy and in the done cycle are ignored.
    repeat (3) @(posedge clk);
    #2 d = m_dones;
    run_xfer(1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #2 check("single_done", m_dones, d + 1);
    run_xfer(1'b0, 1'b0);
    check("second_len", m_len, 154);

    // Abort with reset in stage p=1 at cnt=10.
    repeat (3) @(posedge clk);
    #2 bf_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    budget_ok = 0;
    for (int n = 0; n < 400; n++) begin
      if (m_acc == 74 && ph == 1) begin budget_ok = 1; break; end
      @(posedge clk); #2;
    end
    check("abort_reached", budget_ok, 1);
    check("pre_abort", {a_p, a_k, a_j, a_bf_valid}, {3'd1, 5'd2, 5'd2, 1'b1});
    d = m_dones;
    #1 rst = 1'b0;
    #1 check("async_abort", {a_bf_valid, a_busy, a_done, a_p}, {3'b000, 3'd3});
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    repeat (10) @(posedge clk);
    #2 check("no_done_after_abort", m_dones, d);
    run_xfer(1'b0, 1'b0);
    check("post_abort_len", m_len, 154);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
